inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 123 ++++++++++++
 tb/tb_inst_fetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC into a 1-cycle-latency instruction memory
// and hands fetched words to decode through a skid buffer and output register.
module inst_fetch #(
  parameter int          WORD_WIDTH = 32,
  parameter int          MEM_DEPTH  = 1024,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [WORD_WIDTH-1:0] inst_addr,
  input  logic [WORD_WIDTH-1:0] inst,
  input  logic                  redirect_valid,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_inst,
  output logic [WORD_WIDTH-1:0] out_pc
);

  localparam logic [WORD_WIDTH-1:0] MASK  = WORD_WIDTH'(MEM_DEPTH - 1);
  localparam logic [WORD_WIDTH-1:0] ALIGN = MASK & ~WORD_WIDTH'(3);
  localparam logic [WORD_WIDTH-1:0] PC0   = WORD_WIDTH'(RESET_PC);

  typedef enum logic {EMPTY, FULL} skid_e;

  skid_e                 skid_st, skid_nx;
  logic                  skid_v;
  logic [WORD_WIDTH-1:0] skid_inst, skid_inst_nx;
  logic [WORD_WIDTH-1:0] skid_pc, skid_pc_nx;

  logic [WORD_WIDTH-1:0] pc, pc_nx;
  logic                  rsp_v, rsp_v_nx;
  logic [WORD_WIDTH-1:0] rsp_pc, rsp_pc_nx;

  logic                  out_valid_nx;
  logic [WORD_WIDTH-1:0] out_inst_nx, out_pc_nx;

  logic can_take, issue;

  assign skid_v    = (skid_st == FULL);
  assign inst_addr = pc;
  assign can_take  = ~out_valid | out_ready;
  assign issue     = ~skid_v & can_take & ~redirect_valid;

  always_comb begin
    pc_nx        = pc;
    rsp_v_nx     = 1'b0;
    rsp_pc_nx    = rsp_pc;
    skid_nx      = skid_st;
    skid_inst_nx = skid_inst;
    skid_pc_nx   = skid_pc;
    out_valid_nx = out_valid;
    out_inst_nx  = out_inst;
    out_pc_nx    = out_pc;
    if (redirect_valid) begin
      // Flush everything in flight; the target is fetched next edge.
      pc_nx        = redirect_pc & ALIGN;
      skid_nx      = EMPTY;
      out_valid_nx = 1'b0;
    end else begin
      if (issue) begin
        pc_nx     = (pc + WORD_WIDTH'(4)) & MASK;
        rsp_v_nx  = 1'b1;
        rsp_pc_nx = pc;
      end
      unique case (1'b1)
        rsp_v & ~can_take: begin
          skid_inst_nx = inst;
          skid_pc_nx   = rsp_pc;
          skid_nx      = FULL;
        end
        rsp_v & can_take & skid_v: begin
          out_inst_nx  = skid_inst;
          out_pc_nx    = skid_pc;
          out_valid_nx = 1'b1;
          skid_inst_nx = inst;
          skid_pc_nx   = rsp_pc;
        end
        rsp_v & can_take & ~skid_v: begin
          out_inst_nx  = inst;
          out_pc_nx    = rsp_pc;
          out_valid_nx = 1'b1;
        end
        ~rsp_v & can_take & skid_v: begin
          out_inst_nx  = skid_inst;
          out_pc_nx    = skid_pc;
          out_valid_nx = 1'b1;
          skid_nx      = EMPTY;
        end
        ~rsp_v & can_take & ~skid_v: begin
          out_valid_nx = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= PC0;
      rsp_v     <= 1'b0;
      rsp_pc    <= '0;
      skid_st   <= EMPTY;
      skid_inst <= '0;
      skid_pc   <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else begin
      pc        <= pc_nx;
      rsp_v     <= rsp_v_nx;
      rsp_pc    <= rsp_pc_nx;
      skid_st   <= skid_nx;
      skid_inst <= skid_inst_nx;
      skid_pc   <= skid_pc_nx;
      out_valid <= out_valid_nx;
      out_inst  <= out_inst_nx;
      out_pc    <= out_pc_nx;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: 1-cycle memory model plus a PC-sequence scoreboard
// checking every decode handshake against the expected program order.
module tb_inst_fetch;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  logic [31:0] mem [DEPTH/4];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  bit          acc;
  logic [31:0] apc, ainst;

  inst_fetch #(
    .WORD_WIDTH(32),
    .MEM_DEPTH (DEPTH),
    .RESET_PC  (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr     (inst_addr),
    .inst          (inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) inst <= mem[inst_addr[9:2]];

  // A response must never land while the skid is full and output blocked.
  always @(posedge clk) begin
    if (!rst && dut.rsp_v && dut.skid_v && out_valid && !out_ready) begin
      errors++;
      $display("FAIL overflow at t=%0t got rsp while skid full, required none", $time);
    end
  end

  // Advance one clock; report the handshake seen just before the edge.
  task automatic cycle(output bit a, output logic [31:0] p, output logic [31:0] i);
    a = out_valid && out_ready;
    p = out_pc;
    i = out_inst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    for (int k = 0; k < DEPTH/4; k++) mem[k] = $urandom;
    mem[0] = 32'hA000_0001;
    mem[1] = 32'hB000_0002;
    mem[2] = 32'hC000_0003;
    mem[3] = 32'hD000_0004;
    #12;
    checks++;
    if (inst_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h required 0", inst_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got v=%b pc=%h inst=%h required 0/0/0",
               out_valid, out_pc, out_inst);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || inst_addr !== 32'h4) begin
      errors++;
      $display("FAIL first_edge got v=%b addr=%h required 0/4", out_valid, inst_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hA000_0001) begin
      errors++;
      $display("FAIL second_edge got v=%b pc=%h inst=%h required 1/0/a0000001",
               out_valid, out_pc, out_inst);
    end
    exp_pc = 32'h0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      cycle(acc, apc, ainst);
      checks++;
      if (!acc || apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
        errors++;
        $display("FAIL stream[%0d] got acc=%b pc=%h inst=%h required 1/%h/%h",
                 k, acc, apc, ainst, exp_pc, mem[exp_pc[9:2]]);
      end
      exp_pc = (exp_pc + 4) % DEPTH;
    end
  endtask

  task automatic test_stall();
    logic [31:0] addr0, hpc, hinst;
    int got;
    out_ready = 1'b0;
    addr0 = inst_addr;
    hpc = out_pc;
    hinst = out_inst;
    checks++;
    if (out_valid !== 1'b1 || hpc !== 32'h10) begin
      errors++; $display("FAIL stall_start got v=%b pc=%h required 1/10", out_valid, hpc);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(acc, apc, ainst);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== hpc || out_inst !== hinst
          || inst_addr !== addr0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%h inst=%h addr=%h required 1/%h/%h/%h",
                 k, out_valid, out_pc, out_inst, inst_addr, hpc, hinst, addr0);
      end
    end
    out_ready = 1'b1;
    got = 0;
    for (int b = 0; b < 10 && got < 3; b++) begin
      cycle(acc, apc, ainst);
      if (acc) begin
        checks++;
        if (apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
          errors++;
          $display("FAIL stall_release got pc=%h inst=%h required %h/%h",
                   apc, ainst, exp_pc, mem[exp_pc[9:2]]);
        end
        exp_pc = (exp_pc + 4) % DEPTH;
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL stall_release_timeout got %0d required 3", got);
    end
  endtask

  task automatic test_redirect_skid();
    int got;
    out_ready = 1'b0;
    cycle(acc, apc, ainst);
    cycle(acc, apc, ainst);
    checks++;
    if (out_valid !== 1'b1 || dut.skid_v !== 1'b1) begin
      errors++;
      $display("FAIL pre_redirect got v=%b skid=%b required 1/1", out_valid, dut.skid_v);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle(acc, apc, ainst);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    exp_pc = 32'h40;
    checks++;
    if (out_valid !== 1'b0 || dut.skid_v !== 1'b0 || inst_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect_e0 got v=%b skid=%b addr=%h required 0/0/40",
               out_valid, dut.skid_v, inst_addr);
    end
    cycle(acc, apc, ainst);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_e1 got v=%b required 0", out_valid);
    end
    cycle(acc, apc, ainst);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== mem[16]) begin
      errors++;
      $display("FAIL redirect_e2 got v=%b pc=%h required 1/40", out_valid, out_pc);
    end
    got = 0;
    for (int b = 0; b < 10 && got < 3; b++) begin
      cycle(acc, apc, ainst);
      if (acc) begin
        checks++;
        if (apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
          errors++;
          $display("FAIL redirect_stream got pc=%h required %h", apc, exp_pc);
        end
        exp_pc = (exp_pc + 4) % DEPTH;
        got++;
      end
    end
  endtask

  task automatic test_redirect_align();
    logic [31:0] tgt [2];
    logic [31:0] want [2];
    bit seen;
    tgt[0] = 32'h43;   want[0] = 32'h40;
    tgt[1] = 32'h1404; want[1] = 32'h004;
    for (int t = 0; t < 2; t++) begin
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = tgt[t];
      cycle(acc, apc, ainst);
      redirect_valid = 1'b0;
      checks++;
      if (!acc || apc !== exp_pc) begin
        errors++;
        $display("FAIL redirect_coincident[%0d] got acc=%b pc=%h required 1/%h",
                 t, acc, apc, exp_pc);
      end
      exp_pc = want[t];
      checks++;
      if (inst_addr !== want[t]) begin
        errors++; $display("FAIL redirect_addr[%0d] got %h required %h", t, inst_addr, want[t]);
      end
      seen = 1'b0;
      for (int b = 0; b < 6 && !seen; b++) begin
        cycle(acc, apc, ainst);
        if (acc) begin
          seen = 1'b1;
          checks++;
          if (apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
            errors++;
            $display("FAIL redirect_target[%0d] got pc=%h required %h", t, apc, exp_pc);
          end
          exp_pc = (exp_pc + 4) % DEPTH;
        end
      end
      if (!seen) begin
        errors++; $display("FAIL redirect_timeout[%0d] got none required %h", t, exp_pc);
      end
    end
  endtask

  task automatic test_wrap();
    int got;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3F8;
    cycle(acc, apc, ainst);
    redirect_valid = 1'b0;
    exp_pc = 32'h3F8;
    got = 0;
    for (int b = 0; b < 12 && got < 4; b++) begin
      cycle(acc, apc, ainst);
      checks++;
      if (inst_addr > 32'h3FC) begin
        errors++; $display("FAIL wrap_addr got %h required <=3fc", inst_addr);
      end
      if (acc) begin
        checks++;
        if (apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
          errors++; $display("FAIL wrap_seq got pc=%h required %h", apc, exp_pc);
        end
        exp_pc = (exp_pc + 4) % DEPTH;
        got++;
      end
    end
    checks++;
    if (got != 4 || exp_pc !== 32'h8) begin
      errors++; $display("FAIL wrap_count got %0d required 4", got);
    end
  endtask

  task automatic test_random();
    bit hold, redir;
    logic [31:0] rpc, ppc, pinst;
    int accepts = 0;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom % 4) != 0;
      redir = ($urandom % 20) == 0;
      rpc = $urandom;
      redirect_valid = redir;
      redirect_pc = rpc;
      hold = out_valid && !out_ready && !redir;
      ppc = out_pc;
      pinst = out_inst;
      cycle(acc, apc, ainst);
      if (acc) begin
        accepts++;
        checks++;
        if (apc !== exp_pc || ainst !== mem[exp_pc[9:2]]) begin
          errors++;
          $display("FAIL random_seq[%0d] got pc=%h inst=%h required %h/%h",
                   n, apc, ainst, exp_pc, mem[exp_pc[9:2]]);
        end
        exp_pc = (exp_pc + 4) % DEPTH;
      end
      if (redir) exp_pc = rpc & 32'h3FC;
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== ppc || out_inst !== pinst) begin
          errors++;
          $display("FAIL random_hold[%0d] got v=%b pc=%h required 1/%h", n, out_valid, out_pc, ppc);
        end
      end
      checks++;
      if (inst_addr[1:0] !== 2'b00 || inst_addr >= DEPTH) begin
        errors++; $display("FAIL random_addr[%0d] got %h required aligned <400", n, inst_addr);
      end
    end
    redirect_valid = 1'b0;
    checks++;
    if (accepts < 100) begin
      errors++; $display("FAIL random_throughput got %0d required >=100", accepts);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    cycle(acc, apc, ainst);
    redirect_valid = 1'b0;
    cycle(acc, apc, ainst);
    cycle(acc, apc, ainst);
    out_ready = 1'b0;
    cycle(acc, apc, ainst);
    cycle(acc, apc, ainst);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got v=%b required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0
        || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b pc=%h inst=%h addr=%h required 0/0/0/0",
               out_valid, out_pc, out_inst, inst_addr);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || inst_addr !== 32'h4) begin
      errors++;
      $display("FAIL restart_e1 got v=%b addr=%h required 0/4", out_valid, inst_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== mem[0]) begin
      errors++;
      $display("FAIL restart_e2 got v=%b pc=%h inst=%h required 1/0/%h",
               out_valid, out_pc, out_inst, mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_skid();
    test_redirect_align();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
